ultra_sched: RTL
================

# ultra_sched

Round-robin scheduler for a bank of HC-SR04-style ultrasonic rangers sharing one clock domain. Fires one sensor at a time so echoes never cross-talk: 10 us trigger pulse, time the echo, enforce a guard interval, advance to the next sensor. Latest echo width per sensor is held in a result register file. Completions are also announced as a one-cycle strobe, for LED/HEX display or a host readout.

## Interface

- NUM_SENSORS, 4: number of sensor channels (2..8).
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1_900_000: maximum wait for echo rise, and maximum echo width (38 ms).
- GUARD_CYCLES, 500_000: dead time after each measurement before the next trigger (10 ms).
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run scheduling; sampled only in IDLE and GUARD.
- echo  in  NUM_SENSORS  raw asynchronous echo lines from GPIO.
- trigger  out  NUM_SENSORS  trigger lines; at most one bit high at any time.
- result_valid  out  1  one-cycle strobe: a measurement completed.
- result_id  out  $clog2(NUM_SENSORS)  sensor index of the strobed result.
- result_data  out  32  echo width in clk cycles, zero-extended.
- result_timeout  out  1  strobed result timed out.
- rd_sel  in  $clog2(NUM_SENSORS)  result register select.
- rd_data  out  32  registered copy of selected sensor's last result.
- rd_timeout  out  1  timeout flag of the selected sensor.

## Operation

- Echo inputs pass a 2-flop synchronizer; edge detect uses synced value and its 1-cycle delay.
- States:
  - IDLE: enable=1 -> TRIG for sensor cur.
  - TRIG: trigger[cur]=1; after TRIG_CYCLES cycles -> WAIT_RISE, counter cleared.
  - WAIT_RISE: synced rising edge on echo[cur] -> MEASURE, counter cleared. Counter reaches TIMEOUT_CYCLES -> log timeout, -> GUARD.
  - MEASURE: counter increments each cycle echo stays high. Falling edge -> log counter, -> GUARD. Counter reaches TIMEOUT_CYCLES -> log timeout, data=TIMEOUT_CYCLES, -> GUARD.
  - GUARD: counts GUARD_CYCLES. Then cur advances (NUM_SENSORS-1 wraps to 0): -> TRIG if enable, else IDLE.
- Echo already high at WAIT_RISE entry (stuck line) is not a rising edge; it times out.
- Echoes on non-selected channels are ignored.
- enable deasserted mid-sequence: current sensor completes through GUARD, then IDLE.
- Logging writes result_data/timeout into register cur and pulses result_valid the same cycle.
- Counter is 32 bits; saturation bound is TIMEOUT_CYCLES, so no wrap.

## Timing

- Reset values:
  - state IDLE, cur 0, trigger 0, result_valid 0.
  - result_id 0, result_data 0, result_timeout 0.
  - all result registers 0 with timeout flag 0; rd_data 0, rd_timeout 0.
- Reset mid-operation: trigger drops the cycle after reset is sampled.
- IDLE->TRIG: trigger[cur] rises one cycle after enable is sampled high. Trigger high for exactly TRIG_CYCLES cycles.
- Echo-to-FSM latency is 3 cycles (2 sync + edge register) on both edges, so measured width equals raw echo high cycles.
- result_valid asserts the cycle after the terminating edge/timeout is detected; it is high for exactly 1 cycle.
- rd_data/rd_timeout: 1-cycle latency from rd_sel. A same-cycle log to the selected register is visible the following cycle.
- Minimum trigger-to-trigger spacing: TRIG_CYCLES + 1 + measure + GUARD_CYCLES.

## Structure

- ultra_pkg holds:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GUARD);
  - default timing constants for 50 MHz;
  - the 32-bit result width constant.
- Sub-module ultra_echo_sync: 2-flop synchronizer plus rise/fall pulse outputs, one instance per channel.
- Result register file and FSM live in ultra_sched.

## Test plan

Bench parameters: NUM_SENSORS=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GUARD_CYCLES=10.

- Reset: hold reset 3 cycles, enable=1 -> all outputs 0. trigger=4'b0001 high for exactly 4 cycles starting 1 cycle after release.
- Normal round: echo[0] high for 37 cycles, starting 5 cycles after trigger falls -> result_valid pulse with id=0, data=37, timeout=0. rd_sel=0 then gives rd_data=37.
- No echo on sensor 1 -> timeout strobe id=1, data=0, timeout=1, 100 cycles after trigger falls. Next trigger is 4'b0100 after the guard.
- Long echo on sensor 2 (held 150 cycles) -> id=2, data=100, timeout=1. Glitch on echo[3] during this window is ignored.
- Wrap: after sensor 3 completes, next trigger is 4'b0001. enable=0 during sensor 0 MEASURE -> sensor 0 logs, then IDLE, no further triggers.
- Reset asserted mid-MEASURE -> trigger 0, result registers cleared, no result_valid. Restart begins at sensor 0.

Source files
------------

// File: rtl/ultra_pkg.sv
// Shared types and 50 MHz timing defaults for the ultrasonic ranger scheduler.
// Holds the FSM state enum, default cycle counts and the result word width.
package ultra_pkg;

  localparam int RES_W       = 32;
  localparam int DEF_TRIG    = 500;
  localparam int DEF_TIMEOUT = 1_900_000;
  localparam int DEF_GUARD   = 500_000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_e;

endpackage

// File: rtl/ultra_echo_sync.sv
// Echo line synchronizer: 2-flop sync, delay flop, registered edge pulses.
// Ports: clk, reset (sync, high), echo_i (async), rise_o/fall_o (1-cycle).
module ultra_echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= echo_i;
      s2_q   <= s1_q;
      dly_q  <= s2_q;
      rise_q <= s2_q & ~dly_q;
      fall_q <= ~s2_q & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ultra_sched.sv
// Round-robin ultrasonic ranger scheduler with per-sensor result registers.
// Ports: clk, reset, enable, echo[N], trigger[N], result_* strobe, rd_sel/rd_*.
module ultra_sched
  import ultra_pkg::*;
#(
  parameter int NUM_SENSORS    = 4,
  parameter int TRIG_CYCLES    = DEF_TRIG,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int GUARD_CYCLES   = DEF_GUARD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trigger,
  output logic                           result_valid,
  output logic [$clog2(NUM_SENSORS)-1:0] result_id,
  output logic [RES_W-1:0]               result_data,
  output logic                           result_timeout,
  input  logic [$clog2(NUM_SENSORS)-1:0] rd_sel,
  output logic [RES_W-1:0]               rd_data,
  output logic                           rd_timeout
);

  localparam int IW = $clog2(NUM_SENSORS);

  localparam logic [RES_W-1:0] TRIG_LAST  = RES_W'(TRIG_CYCLES - 1);
  localparam logic [RES_W-1:0] WAIT_LAST  = RES_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RES_W-1:0] TO_VAL     = RES_W'(TIMEOUT_CYCLES);
  localparam logic [RES_W-1:0] GUARD_LAST = RES_W'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0]    CUR_LAST   = IW'(NUM_SENSORS - 1);

  logic [NUM_SENSORS-1:0] rise;
  logic [NUM_SENSORS-1:0] fall;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sync
    ultra_echo_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .echo_i (echo[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  state_e                 state_q, state_d;
  logic [IW-1:0]          cur_q, cur_d;
  logic [RES_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;

  logic             log_en;
  logic [RES_W-1:0] log_data;
  logic             log_to;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    log_en   = 1'b0;
    log_data = '0;
    log_to   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (rise[cur_q]) begin
          // The entry cycle is the first high cycle of the echo.
          state_d = MEASURE;
          cnt_d   = RES_W'(1);
        end else if (cnt_q == WAIT_LAST) begin
          log_en  = 1'b1;
          log_to  = 1'b1;
          state_d = GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        // A falling edge beats saturation on the same cycle.
        if (fall[cur_q]) begin
          log_en   = 1'b1;
          log_data = cnt_q;
          state_d  = GUARD;
          cnt_d    = '0;
        end else if (cnt_q == TO_VAL) begin
          log_en   = 1'b1;
          log_to   = 1'b1;
          log_data = TO_VAL;
          state_d  = GUARD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cur_d   = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
          state_d = enable ? TRIG : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered one-hot trigger from next state keeps the pins glitch-free.
  always_comb begin
    trig_d = '0;
    if (state_d == TRIG) trig_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  logic [RES_W-1:0]       res_q [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] to_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) res_q[i] <= '0;
      to_q <= '0;
    end else if (log_en) begin
      res_q[cur_q] <= log_data;
      to_q[cur_q]  <= log_to;
    end
  end

  logic             vld_q;
  logic [IW-1:0]    id_q;
  logic [RES_W-1:0] data_q;
  logic             sto_q;
  logic [RES_W-1:0] rdd_q;
  logic             rdt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
      sto_q  <= 1'b0;
      rdd_q  <= '0;
      rdt_q  <= 1'b0;
    end else begin
      vld_q <= log_en;
      if (log_en) begin
        id_q   <= cur_q;
        data_q <= log_data;
        sto_q  <= log_to;
      end
      // Bypass so a log to the selected entry shows up next cycle.
      if (log_en && (cur_q == rd_sel)) begin
        rdd_q <= log_data;
        rdt_q <= log_to;
      end else begin
        rdd_q <= res_q[rd_sel];
        rdt_q <= to_q[rd_sel];
      end
    end
  end

  assign trigger        = trig_q;
  assign result_valid   = vld_q;
  assign result_id      = id_q;
  assign result_data    = data_q;
  assign result_timeout = sto_q;
  assign rd_data        = rdd_q;
  assign rd_timeout     = rdt_q;

endmodule
